regfile_mp_sb: RTL and testbench



---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_scoreboard.sv | 55 +++++
 rtl/regfile_mp_sb.sv | 85 ++++++++
 tb/tb_regfile_mp_sb.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, register typedefs and packed-port helpers for the multi-port register file.
package regfile_pkg;

    localparam int DEF_AWIDTH = 5;
    localparam int DEF_DWIDTH = 32;

    // Widest packed port vector and field the slice helper handles.
    localparam int MAX_VEC   = 512;
    localparam int MAX_FIELD = 64;

    typedef logic [DEF_AWIDTH-1:0] reg_addr_t;
    typedef logic [DEF_DWIDTH-1:0] reg_data_t;

    // Field k of width w from a packed vector; callers truncate to their own width.
    function automatic logic [MAX_FIELD-1:0] port_field(
        input logic [MAX_VEC-1:0] vec,
        input int                 k,
        input int                 w
    );
        logic [MAX_VEC-1:0] shifted;
        shifted = vec >> (k * w);
        return shifted[MAX_FIELD-1:0];
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, flush squashes; per-port stall lookup.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int AWIDTH   = DEF_AWIDTH,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NWRITE-1:0]        wen_eff,
    input  logic [NWRITE*AWIDTH-1:0] waddr,
    input  logic                     issue_valid,
    input  logic [AWIDTH-1:0]        issue_rd,
    input  logic                     flush,
    input  logic [NREAD*AWIDTH-1:0]  raddr,
    output logic [NREAD-1:0]         rbusy
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [DEPTH-1:0] busy;
    logic             issue_eff;

    assign issue_eff = issue_valid & ~((ZERO_REG != 0) && (issue_rd == '0));

    // NOTE: later non-blocking assignments to the same bit win, so the issue set placed after the clears takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            for (int k = 0; k < NWRITE; k++) begin
                if (wen_eff[k]) busy[waddr[k*AWIDTH +: AWIDTH]] <= 1'b0;
            end
            if (issue_eff) busy[issue_rd] <= 1'b1;
        end
    end

    // A write landing this cycle is bypassed to the reader, so it does not stall.
    always_comb begin
        rbusy = '0;
        for (int i = 0; i < NREAD; i++) begin
            logic hit;
            hit = 1'b0;
            for (int k = 0; k < NWRITE; k++) begin
                if (wen_eff[k] && (waddr[k*AWIDTH +: AWIDTH] == raddr[i*AWIDTH +: AWIDTH])) hit = 1'b1;
            end
            rbusy[i] = busy[raddr[i*AWIDTH +: AWIDTH]] & ~hit;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-to-read bypass and busy scoreboard.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int AWIDTH   = DEF_AWIDTH,
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NWRITE-1:0]        wen,
    input  logic [NWRITE*AWIDTH-1:0] waddr,
    input  logic [NWRITE*DWIDTH-1:0] wdata,
    input  logic [NREAD*AWIDTH-1:0]  raddr,
    output logic [NREAD*DWIDTH-1:0]  rdata,
    output logic [NREAD-1:0]         rbusy,
    input  logic                     issue_valid,
    input  logic [AWIDTH-1:0]        issue_rd,
    input  logic                     flush
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wa  [NWRITE];
    logic [DWIDTH-1:0] wd  [NWRITE];
    logic [AWIDTH-1:0] ra  [NREAD];
    logic [DWIDTH-1:0] rd  [NREAD];
    logic [NWRITE-1:0] wen_eff;

    for (genvar k = 0; k < NWRITE; k++) begin : g_wport
        assign wa[k]      = AWIDTH'(port_field(MAX_VEC'(waddr), k, AWIDTH));
        assign wd[k]      = DWIDTH'(port_field(MAX_VEC'(wdata), k, DWIDTH));
        assign wen_eff[k] = wen[k] & ~((ZERO_REG != 0) && (wa[k] == '0));
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rport
        assign ra[i] = AWIDTH'(port_field(MAX_VEC'(raddr), i, AWIDTH));
        assign rdata[i*DWIDTH +: DWIDTH] = rd[i];
    end

    // NOTE: the storage array is reset here because software relies on every register reading zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
        end else begin
            for (int k = 0; k < NWRITE; k++) begin
                if (wen_eff[k]) mem[wa[k]] <= wd[k];
            end
        end
    end

    // NOTE: every output gets a default before the loops, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rd[i] = mem[ra[i]];
            for (int k = 0; k < NWRITE; k++) begin
                if (wen_eff[k] && (wa[k] == ra[i])) rd[i] = wd[k];
            end
            if ((ZERO_REG != 0) && (ra[i] == '0)) rd[i] = '0;
            // Bypass data must not leak out while reset is held.
            if (rst) rd[i] = '0;
        end
    end

    regfile_scoreboard #(
        .AWIDTH   (AWIDTH),
        .NREAD    (NREAD),
        .NWRITE   (NWRITE),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .wen_eff     (wen_eff),
        .waddr       (waddr),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .raddr       (raddr),
        .rbusy       (rbusy)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb with an array-based reference model checked every cycle.
module tb_regfile_mp_sb;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int NW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [NW-1:0]  wen;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]  rbusy;
    logic           issue_valid;
    logic [AW-1:0]  issue_rd;
    logic           flush;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_mem  [32];
    bit            model_busy [32];

    regfile_mp_sb #(.AWIDTH(AW), .DWIDTH(DW), .NREAD(NR), .NWRITE(NW), .ZERO_REG(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .raddr       (raddr),
        .rdata       (rdata),
        .rbusy       (rbusy),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit wr_eff(input int k);
        return wen[k] && (waddr[k*AW +: AW] != 0);
    endfunction

    // Value a reader must see: newest landing write (highest port) else stored value; r0 is always 0.
    function automatic logic [DW-1:0] exp_read(input int a);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = model_mem[a];
        for (int k = 0; k < NW; k++)
            if (wr_eff(k) && int'(waddr[k*AW +: AW]) == a) v = wdata[k*DW +: DW];
        return v;
    endfunction

    function automatic bit exp_busy(input int a);
        for (int k = 0; k < NW; k++)
            if (wr_eff(k) && int'(waddr[k*AW +: AW]) == a) return 1'b0;
        return model_busy[a];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < 32; a++) begin
                model_mem[a]  = '0;
                model_busy[a] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NW; k++)
                if (wr_eff(k)) model_mem[waddr[k*AW +: AW]] = wdata[k*DW +: DW];
            if (flush) begin
                for (int a = 0; a < 32; a++) model_busy[a] = 1'b0;
            end else begin
                for (int k = 0; k < NW; k++)
                    if (wr_eff(k)) model_busy[waddr[k*AW +: AW]] = 1'b0;
                if (issue_valid && issue_rd != 0) model_busy[issue_rd] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin
                check("model_rdata", rdata[i*DW +: DW], exp_read(int'(raddr[i*AW +: AW])));
                check("model_rbusy", rbusy[i], exp_busy(int'(raddr[i*AW +: AW])));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        wen = '0;
        issue_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic wr(input int k, input int a, input logic [DW-1:0] d);
        wen[k] = 1'b1;
        waddr[k*AW +: AW] = AW'(a);
        wdata[k*DW +: DW] = d;
    endtask

    task automatic rd(input int i, input int a);
        raddr[i*AW +: AW] = AW'(a);
    endtask

    task automatic issue(input int a);
        issue_valid = 1'b1;
        issue_rd = AW'(a);
    endtask

    initial begin
        rst = 1'b1;
        wen = '0; waddr = '0; wdata = '0; raddr = '0;
        issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
        #2;
        check("reset_rdata0", rdata[0 +: DW], 32'h0);
        check("reset_rbusy", rbusy, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;

        // Async reset clears storage and busy without a clock edge.
        wr(0, 5, 32'hDEADBEEF); rd(0, 5);
        step();
        issue(5);
        check("r5_written", rdata[0 +: DW], 32'hDEADBEEF);
        step();
        check("r5_busy", rbusy[0], 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rst_r5_rdata", rdata[0 +: DW], 32'h0);
        check("rst_r5_rbusy", rbusy[0], 1'b0);
        #1 rst = 1'b0;

        // Ordinary write and ignored write to r0.
        step();
        wr(0, 3, 32'h12345678); wr(1, 0, 32'hFFFFFFFF);
        step();
        rd(0, 3); rd(1, 0);
        #1;
        check("r3_read", rdata[0 +: DW], 32'h12345678);
        check("r0_read", rdata[DW +: DW], 32'h0);

        // Same-address collision: port 1 wins for bypass and storage.
        step();
        wr(0, 7, 32'hAAAA0000); wr(1, 7, 32'h5555FFFF); rd(0, 7);
        #1;
        check("r7_bypass", rdata[0 +: DW], 32'h5555FFFF);
        step();
        #1;
        check("r7_stored", rdata[0 +: DW], 32'h5555FFFF);

        // Scoreboard set, then clear by writeback with bypass.
        issue(9);
        step();
        rd(0, 9);
        #1;
        check("r9_busy", rbusy[0], 1'b1);
        wr(1, 9, 32'h42);
        #1;
        check("r9_wb_rbusy", rbusy[0], 1'b0);
        check("r9_wb_rdata", rdata[0 +: DW], 32'h42);
        step();
        #1;
        check("r9_after_rbusy", rbusy[0], 1'b0);
        check("r9_after_rdata", rdata[0 +: DW], 32'h42);

        // Issue and write on the same edge: set wins.
        issue(4); wr(0, 4, 32'h10);
        step();
        rd(0, 4);
        #1;
        check("r4_busy", rbusy[0], 1'b1);
        check("r4_rdata", rdata[0 +: DW], 32'h10);

        // r0 never becomes busy.
        issue(0);
        step();
        rd(1, 0);
        #1;
        check("r0_not_busy", rbusy[1], 1'b0);

        // Flush overrides a same-cycle issue; a same-cycle write still commits.
        issue(1); step();
        issue(2); step();
        issue(3); rd(1, 1);
        #1;
        check("r1_busy_pre_flush", rbusy[1], 1'b1);
        step();
        flush = 1'b1; issue(6); wr(0, 12, 32'hCAFE0012);
        step();
        rd(0, 1); rd(1, 2);
        #1;
        check("flush_r1", rbusy[0], 1'b0);
        check("flush_r2", rbusy[1], 1'b0);
        rd(0, 3); rd(1, 6);
        #1;
        check("flush_r3", rbusy[0], 1'b0);
        check("flush_r6", rbusy[1], 1'b0);
        rd(0, 12);
        #1;
        check("flush_write_commit", rdata[0 +: DW], 32'hCAFE0012);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
